// File: rtl/ifb_pkg.sv
// Shared FSM state type and default sizing for the instruction fetch buffer.
package ifb_pkg;

  localparam int IFB_ADDR_W  = 10;
  localparam int IFB_INSTR_W = 32;
  localparam int IFB_DEPTH   = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2
  } ifb_state_e;

endpackage

// File: rtl/ifb_fifo.sv
// Instruction FIFO: wrap-bit pointers, full/empty detection, flush clears it in one edge.
module ifb_fifo
  import ifb_pkg::*;
#(
  parameter int WIDTH = IFB_INSTR_W + IFB_ADDR_W,
  parameter int DEPTH = IFB_DEPTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_wptr == r_rptr);
  assign full      = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_push = push && !full && !flush;
  assign w_do_pop  = pop && !empty && !flush;

  // Storage is never reset, so the head is masked to zero while empty.
  assign rdata = empty ? '0 : r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_do_pop)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/instr_fetch_buffer.sv
// Single-outstanding instruction fetcher feeding a small FIFO toward decode.
// Optional IFB_BYPASS_EN forwards an ack straight to decode when the FIFO is empty.
module instr_fetch_buffer
  import ifb_pkg::*;
#(
  parameter int ADDR_W  = IFB_ADDR_W,
  parameter int INSTR_W = IFB_INSTR_W,
  parameter int DEPTH   = IFB_DEPTH
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               halt,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  pc_address,
  output logic               pc_hold,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc
);

  localparam int EW = INSTR_W + ADDR_W;

  ifb_state_e          r_state;
  ifb_state_e          w_state_nxt;
  logic                r_pc_hold;
  logic [ADDR_W-1:0]   r_imem_addr;
  logic                w_issue;
  logic                w_push;
  logic                w_fifo_push;
  logic                w_pop;
  logic                w_empty;
  logic                w_full;
  logic [EW-1:0]       w_rd_entry;
  logic [INSTR_W-1:0]  w_rd_data;
  logic [ADDR_W-1:0]   w_rd_pc;

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_push      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!halt && !flush && !w_full) begin
          w_issue     = 1'b1;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_ack) begin
          w_push      = !flush;
          w_state_nxt = ST_IDLE;
        end else if (flush) begin
          w_state_nxt = ST_DISCARD;
        end
      end
      ST_DISCARD: begin
        if (imem_ack) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // pc_hold drops for exactly the cycle after an issue so the PC steps once per fetch.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_pc_hold   <= 1'b1;
      r_imem_addr <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc_hold <= !w_issue;
      if (w_issue) r_imem_addr <= pc_address;
    end
  end

  assign pc_hold   = r_pc_hold;
  assign imem_req  = (r_state != ST_IDLE);
  assign imem_addr = r_imem_addr;
  assign w_pop     = instr_valid && instr_ready && !w_empty;
  assign w_rd_data = w_rd_entry[ADDR_W +: INSTR_W];
  assign w_rd_pc   = w_rd_entry[ADDR_W-1:0];

`ifdef IFB_BYPASS_EN
  logic w_byp;
  assign w_byp       = w_empty && imem_ack && (r_state == ST_WAIT) && !flush;
  assign w_fifo_push = w_push && !(w_byp && instr_ready);
  assign instr_valid = !w_empty || w_byp;
  assign instr_out   = w_byp ? imem_data   : w_rd_data;
  assign instr_pc    = w_byp ? r_imem_addr : w_rd_pc;
`else
  assign w_fifo_push = w_push;
  assign instr_valid = !w_empty;
  assign instr_out   = w_rd_data;
  assign instr_pc    = w_rd_pc;
`endif

  ifb_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .push  (w_fifo_push),
    .pop   (w_pop),
    .wdata ({imem_data, r_imem_addr}),
    .rdata (w_rd_entry),
    .empty (w_empty),
    .full  (w_full)
  );

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Bench for instr_fetch_buffer: directed vector table, corner sequences, randomized run against a queue model.
module tb_instr_fetch_buffer;

  localparam int AW = 10;
  localparam int IW = 32;
  localparam int DP = 4;

  logic          clock = 1'b0;
  logic          reset, halt, flush, imem_ack, instr_ready;
  logic [AW-1:0] pc_address;
  logic [IW-1:0] imem_data;
  logic          pc_hold, imem_req, instr_valid;
  logic [AW-1:0] imem_addr, instr_pc;
  logic [IW-1:0] instr_out;

  always #5 clock = ~clock;

  instr_fetch_buffer #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH(DP)) dut (
    .clock       (clock),
    .reset       (reset),
    .halt        (halt),
    .flush       (flush),
    .pc_address  (pc_address),
    .pc_hold     (pc_hold),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
    end
  endtask

  // Directed vectors: halt=0, flush=0, instr_ready=1 throughout.
  typedef struct packed {
    logic          rst;
    logic          ack;
    logic [IW-1:0] data;
    logic [AW-1:0] pc;
    logic          chk;
    logic          req;
    logic [AW-1:0] addr;
    logic          hold;
    logic          valid;
    logic [IW-1:0] out;
    logic [AW-1:0] ipc;
  } vec_t;

  vec_t tv [15];

  // Behavioural reference: a queue of {data, addr}, one pending-request flag, one drop flag.
  logic [IW+AW-1:0] m_q [$];
  bit               m_known = 0;
  bit               m_pend, m_drop, m_hold;
  logic [AW-1:0]    m_addr;
  bit               auto_ack = 0, lat_rand = 0, spur = 0;
  int               lat = 0, lat_fix = 0, wcnt = 0;
  logic [AW-1:0]    flush_tgt = '0;
  int               n_lowhold, n_req_cyc, n_pops;
  bit               seen_dead, last_valid;
  logic [AW-1:0]    pop_pcs [$];

  task automatic tick();
    bit            e_val, byp, issue, push;
    logic [IW-1:0] e_out;
    logic [AW-1:0] e_ipc, pc_n;
    if (auto_ack) begin
      imem_ack  = m_pend ? (wcnt >= lat) : spur;
      imem_data = $urandom;
    end
    @(negedge clock);
    byp = 1'b0;
`ifdef IFB_BYPASS_EN
    byp = (m_q.size() == 0) && imem_ack && m_pend && !m_drop && !flush;
`endif
    if (byp) begin
      e_val = 1'b1; e_out = imem_data; e_ipc = m_addr;
    end else if (m_q.size() > 0) begin
      e_val = 1'b1; {e_out, e_ipc} = m_q[0];
    end else begin
      e_val = 1'b0; e_out = '0; e_ipc = '0;
    end
    if (m_known) begin
      chk("imem_req",    32'(imem_req),    32'(m_pend));
      chk("imem_addr",   32'(imem_addr),   32'(m_addr));
      chk("pc_hold",     32'(pc_hold),     32'(m_hold));
      chk("instr_valid", 32'(instr_valid), 32'(e_val));
      chk("instr_out",   instr_out,        e_out);
      chk("instr_pc",    32'(instr_pc),    32'(e_ipc));
    end
    last_valid = (instr_valid === 1'b1);
    if (instr_valid === 1'b1 && instr_out === 32'hDEADBEEF) seen_dead = 1'b1;
    if (pc_hold === 1'b0) n_lowhold++;
    if (imem_req === 1'b1) n_req_cyc++;
    if (instr_valid === 1'b1 && instr_ready) begin
      n_pops++;
      pop_pcs.push_back(instr_pc);
    end
    @(posedge clock);
    pc_n = pc_address;
    if (reset)        pc_n = '0;
    else if (flush)   pc_n = flush_tgt;
    else if (!m_hold) pc_n = pc_address + 10'd1;
    if (reset) begin
      m_q.delete();
      m_pend = 0; m_drop = 0; m_hold = 1; m_addr = '0; wcnt = 0;
      m_known = 1;
    end else begin
      issue = !m_pend && !halt && !flush && (m_q.size() < DP);
      push  = 1'b0;
      if (m_pend && imem_ack) begin
        push = !m_drop && !flush; m_pend = 0; m_drop = 0; wcnt = 0;
      end else if (m_pend) begin
        if (flush) m_drop = 1;
        wcnt++;
      end
      if (flush) m_q.delete();
      else begin
        if (e_val && instr_ready && !byp) void'(m_q.pop_front());
        if (push && !(byp && instr_ready)) m_q.push_back({imem_data, m_addr});
      end
      m_hold = !issue;
      if (issue) begin
        m_addr = pc_address; m_pend = 1; wcnt = 0;
        lat = lat_rand ? int'($urandom_range(0, 3)) : lat_fix;
      end
    end
    cyc++;
    #1;
    pc_address = pc_n;
  endtask

  task automatic do_reset();
    reset = 1; halt = 0; flush = 0; imem_ack = 0; spur = 0; auto_ack = 0; lat_rand = 0;
    instr_ready = 1; imem_data = '0;
    tick(); tick();
    reset = 0;
  endtask

  task automatic reach_two_pending(output bit found);
    found = 0;
    instr_ready = 0; auto_ack = 1; lat_fix = 0;
    for (int k = 0; k < 20; k++) begin
      if (m_q.size() == 2 && m_pend) begin found = 1; break; end
      tick();
    end
    auto_ack = 0;
    chk("reach_two_pending", 32'(found), 32'd1);
  endtask

  initial begin
    bit found;
    reset = 1; halt = 0; flush = 0; imem_ack = 0; instr_ready = 1;
    imem_data = '0; pc_address = '0;

    tv[0]  = {1'b1, 1'b0, 32'h0,         10'h0, 1'b0, 1'b0, 10'h0, 1'b0, 1'b0, 32'h0,         10'h0};
    tv[1]  = {1'b1, 1'b0, 32'h0,         10'h0, 1'b1, 1'b0, 10'h0, 1'b1, 1'b0, 32'h0,         10'h0};
    tv[2]  = {1'b0, 1'b0, 32'h0,         10'h0, 1'b1, 1'b0, 10'h0, 1'b1, 1'b0, 32'h0,         10'h0};
    tv[3]  = {1'b0, 1'b0, 32'h0,         10'h0, 1'b1, 1'b1, 10'h0, 1'b0, 1'b0, 32'h0,         10'h0};
    tv[4]  = {1'b0, 1'b0, 32'h0,         10'h1, 1'b1, 1'b1, 10'h0, 1'b1, 1'b0, 32'h0,         10'h0};
    tv[5]  = {1'b0, 1'b1, 32'hA000_0000, 10'h1, 1'b1, 1'b1, 10'h0, 1'b1, 1'b0, 32'h0,         10'h0};
    tv[6]  = {1'b0, 1'b0, 32'h0,         10'h1, 1'b1, 1'b0, 10'h0, 1'b1, 1'b1, 32'hA000_0000, 10'h0};
    tv[7]  = {1'b0, 1'b0, 32'h0,         10'h1, 1'b1, 1'b1, 10'h1, 1'b0, 1'b0, 32'h0,         10'h0};
    tv[8]  = {1'b0, 1'b0, 32'h0,         10'h2, 1'b1, 1'b1, 10'h1, 1'b1, 1'b0, 32'h0,         10'h0};
    tv[9]  = {1'b0, 1'b1, 32'hA000_0001, 10'h2, 1'b1, 1'b1, 10'h1, 1'b1, 1'b0, 32'h0,         10'h0};
    tv[10] = {1'b0, 1'b0, 32'h0,         10'h2, 1'b1, 1'b0, 10'h1, 1'b1, 1'b1, 32'hA000_0001, 10'h1};
    tv[11] = {1'b0, 1'b0, 32'h0,         10'h2, 1'b1, 1'b1, 10'h2, 1'b0, 1'b0, 32'h0,         10'h0};
    tv[12] = {1'b0, 1'b0, 32'h0,         10'h3, 1'b1, 1'b1, 10'h2, 1'b1, 1'b0, 32'h0,         10'h0};
    tv[13] = {1'b0, 1'b1, 32'hA000_0002, 10'h3, 1'b1, 1'b1, 10'h2, 1'b1, 1'b0, 32'h0,         10'h0};
    tv[14] = {1'b0, 1'b0, 32'h0,         10'h3, 1'b1, 1'b0, 10'h2, 1'b1, 1'b1, 32'hA000_0002, 10'h2};

`ifndef IFB_BYPASS_EN
    for (int i = 0; i < 15; i++) begin
      #1;
      reset = tv[i].rst; imem_ack = tv[i].ack; imem_data = tv[i].data; pc_address = tv[i].pc;
      @(negedge clock);
      if (tv[i].chk) begin
        chk("vec_req",   32'(imem_req),    32'(tv[i].req));
        chk("vec_addr",  32'(imem_addr),   32'(tv[i].addr));
        chk("vec_hold",  32'(pc_hold),     32'(tv[i].hold));
        chk("vec_valid", 32'(instr_valid), 32'(tv[i].valid));
        chk("vec_out",   instr_out,        tv[i].out);
        chk("vec_ipc",   32'(instr_pc),    32'(tv[i].ipc));
      end
      @(posedge clock);
    end
`endif
    #1;

    // Fill with decode stalled: four fetches, then idle with pc_hold high.
    do_reset();
    instr_ready = 0; auto_ack = 1; lat_fix = 0; n_lowhold = 0;
    repeat (12) tick();
    chk("fill_issues", 32'(n_lowhold), 32'd4);
    chk("fill_req",    32'(imem_req),  32'd0);
    chk("fill_hold",   32'(pc_hold),   32'd1);
    pop_pcs.delete(); instr_ready = 1;
    repeat (4) tick();
    chk("drain_count", 32'(pop_pcs.size()), 32'd4);
    for (int i = 0; i < 4 && i < pop_pcs.size(); i++) chk("drain_order", 32'(pop_pcs[i]), 32'(i));

    // Flush while waiting; the late word must vanish and the refetch uses the branch target.
    do_reset();
    seen_dead = 0;
    tick();
    flush = 1; flush_tgt = 10'h040; tick(); flush = 0;
    tick(); tick();
    imem_ack = 1; imem_data = 32'hDEADBEEF; tick(); imem_ack = 0;
    tick();
    chk("flush_req",     32'(imem_req),  32'd1);
    chk("flush_newaddr", 32'(imem_addr), 32'h040);
    imem_ack = 1; imem_data = 32'h0000_0040; tick(); imem_ack = 0;
    repeat (3) tick();
    chk("flush_dead_seen", 32'(seen_dead), 32'd0);

    // Flush coinciding with ack while two entries are buffered.
    do_reset();
    reach_two_pending(found);
    imem_ack = 1; flush = 1; imem_data = 32'h5555_AAAA; tick();
    imem_ack = 0; flush = 0;
    chk("flushack_valid", 32'(instr_valid), 32'd0);
    chk("flushack_req",   32'(imem_req),    32'd0);

    // Push and pop in one edge with two buffered: two entries remain.
    do_reset();
    reach_two_pending(found);
    imem_ack = 1; instr_ready = 1; halt = 1; imem_data = 32'h7777_0003; tick();
    imem_ack = 0; n_pops = 0;
    repeat (6) tick();
    chk("pushpop_remaining", 32'(n_pops),      32'd2);
    chk("pushpop_drained",   32'(instr_valid), 32'd0);
    halt = 0;

    // Halt during an outstanding fetch: it completes, nothing new is issued, buffer drains.
    do_reset();
    tick();
    halt = 1; tick(); tick();
    imem_ack = 1; imem_data = 32'h1234_5678; tick(); imem_ack = 0;
    n_req_cyc = 0; n_pops = 0;
    repeat (5) tick();
    chk("halt_noreq",  32'(n_req_cyc),   32'd0);
    chk("halt_pops",   32'(n_pops),      32'd1);
    chk("halt_valid",  32'(instr_valid), 32'd0);
    halt = 0;

    // Reset in the middle of a fetch; a stray ack afterwards is ignored.
    do_reset();
    tick(); tick();
    reset = 1; tick(); reset = 0;
    halt = 1; imem_ack = 1; imem_data = 32'hBAD0_0001; tick(); imem_ack = 0;
    chk("rst_stray_valid", 32'(instr_valid), 32'd0);
    chk("rst_stray_req",   32'(imem_req),    32'd0);
    halt = 0;

    // Ack into an empty buffer with decode ready: same-cycle valid only with the bypass.
    do_reset();
    tick(); tick();
    imem_ack = 1; imem_data = 32'hCAFE_0001; tick(); imem_ack = 0;
`ifdef IFB_BYPASS_EN
    chk("byp_ack_cycle", 32'(last_valid), 32'd1);
`else
    chk("byp_ack_cycle", 32'(last_valid), 32'd0);
`endif
    tick();
`ifdef IFB_BYPASS_EN
    chk("byp_next_cycle", 32'(last_valid), 32'd0);
`else
    chk("byp_next_cycle", 32'(last_valid), 32'd1);
`endif

    // Randomized traffic against the reference model.
    do_reset();
    auto_ack = 1; lat_rand = 1;
    for (int i = 0; i < 3000; i++) begin
      halt        = ($urandom_range(0, 9) == 0);
      flush       = ($urandom_range(0, 19) == 0);
      flush_tgt   = 10'($urandom);
      instr_ready = ($urandom_range(0, 9) < 6);
      spur        = ($urandom_range(0, 29) == 0);
      reset       = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 0; halt = 0; flush = 0; spur = 0; auto_ack = 0; imem_ack = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout cyc=%0d got=running expected=finished", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instr_fetch_buffer.md
INSTR_FETCH_BUFFER -- requirements
Module: instr_fetch_buffer

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, instruction address width.
REQ-002 SHALL have parameter INSTR_W, default 32, instruction word width.
REQ-003 SHALL have parameter DEPTH, default 4, buffer entries; power of two, at least 2.
REQ-004 SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port halt, input, 1 bit: processor halt; blocks new fetches.
REQ-007 SHALL have port flush, input, 1 bit: taken branch or jump; discards buffered and in-flight instructions.
REQ-008 SHALL have port pc_address, input, ADDR_W bits: current PC output; stable at rising edge.
REQ-009 SHALL have port pc_hold, output, 1 bit: registered; ORed into the PC halt input by the integrator.
REQ-010 SHALL have port imem_req, output, 1 bit: instruction memory request, held until imem_ack.
REQ-011 SHALL have port imem_addr, output, ADDR_W bits: address of the outstanding request.
REQ-012 SHALL have port imem_ack, input, 1 bit: memory returns imem_data this cycle.
REQ-013 SHALL have port imem_data, input, INSTR_W bits: fetched instruction word.
REQ-014 SHALL have port instr_valid, output, 1 bit: instr_out is valid for decode.
REQ-015 SHALL have port instr_ready, input, 1 bit: decode accepts instr_out this cycle.
REQ-016 SHALL have port instr_out, output, INSTR_W bits: oldest buffered instruction.
REQ-017 SHALL have port instr_pc, output, ADDR_W bits: address of instr_out.

Function
REQ-018 SHALL implement FSM IDLE/WAIT/DISCARD with at most one outstanding request.
REQ-019 IDLE SHALL issue when halt=0, flush=0, and count+1<=DEPTH; issue latches pc_address into imem_addr, sets imem_req=1, and moves to WAIT.
REQ-020 WAIT SHALL, on imem_ack, push {imem_data, imem_addr} into the buffer, clear imem_req, and return to IDLE; it SHALL NOT issue in the ack cycle.
REQ-021 WAIT SHALL, on flush without imem_ack, move to DISCARD, keep imem_req until ack, and drop the data on ack, then go to IDLE.
REQ-022 flush together with imem_ack in WAIT SHALL drop the data and go to IDLE.
REQ-023 flush SHALL empty the buffer in the same edge, overriding any push or pop.
REQ-024 pc_hold SHALL be 0 for exactly the one cycle following each issue edge and 1 at all other times, so the PC advances once per fetch.
REQ-025 A pop SHALL occur when instr_valid and instr_ready are both 1; a push and a pop in the same cycle SHALL leave count unchanged.
REQ-026 Read and write pointers SHALL be log2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
REQ-027 Buffer empty SHALL be pointers equal; buffer full SHALL be the MSBs differing with the remaining bits equal.
REQ-028 Without bypass, instr_valid SHALL be !empty, giving one-cycle latency from ack to instr_valid.
REQ-029 halt=1 SHALL allow an outstanding request to complete and SHALL allow the buffer to drain.
REQ-030 instr_out and instr_pc SHALL be held stable while instr_valid=1 and instr_ready=0.

Reset
REQ-031 reset SHALL force: FSM=IDLE, pointers=0, imem_req=0, imem_addr=0, pc_hold=1, instr_valid=0, instr_out=0, instr_pc=0.
REQ-032 reset mid-WAIT SHALL abandon the request; a later imem_ack with no request pending SHALL be ignored.
REQ-033 reset SHALL have priority over flush, halt and imem_ack.

Configuration
REQ-034 Macro IFB_BYPASS_EN, when defined, SHALL present imem_data and imem_addr combinationally on instr_out and instr_pc with instr_valid=1 when the buffer is empty, ack arrives and the state is not DISCARD. The word SHALL then be pushed only if instr_ready=0.
REQ-035 Without IFB_BYPASS_EN, no combinational path SHALL exist from imem_ack or imem_data to any output.

Structure
REQ-036 Package ifb_pkg SHALL hold the FSM state enum and default constants for ADDR_W, INSTR_W and DEPTH.
REQ-037 The storage SHALL be sub-module ifb_fifo (pointers, full/empty, flush clear); the FSM and pc_hold SHALL live in the top module.

Verification
REQ-038 Reset, then pc_address=0x000, ack 2 cycles after each request, instr_ready=1 -> instr_pc sequence 0x000, 0x001, 0x002; pc_hold low once per fetch.
REQ-039 instr_ready=0 for 10 cycles -> exactly 4 fetches issued, then imem_req stays 0 and pc_hold=1; on releasing ready, 4 instructions pop in order.
REQ-040 flush in WAIT, ack 3 cycles later with data 0xDEADBEEF -> word never appears on instr_out; next request uses the new pc_address 0x040.
REQ-041 flush in the ack cycle and push+pop in the same cycle with count=2 -> data dropped, buffer empty; in the push+pop case count stays 2.
REQ-042 halt=1 during WAIT -> ack completes, no further imem_req, buffer drains to instr_valid=0.
REQ-043 With IFB_BYPASS_EN, buffer empty and ack with instr_ready=1 -> instr_valid=1 in the ack cycle and the buffer stays empty; without the macro, instr_valid rises one cycle later.
